// File: rtl/axil_uart_lite_responder.sv
// ============================================================================
//  Module   : axil_uart_lite_responder
//  Purpose  : AXI4-Lite slave presenting the UART Lite register map, with
//             TX/RX byte FIFOs bridged to valid/ready byte streams.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axil_uart_lite_responder #(
   parameter int ADDR_WIDTH = 28,
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   // AXI4-Lite write address / data / response
   input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
   input  logic [2:0]                s_axi_awprot,
   input  logic                      s_axi_awvalid,
   output logic                      s_axi_awready,
   input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
   input  logic                      s_axi_wvalid,
   output logic                      s_axi_wready,
   output logic [1:0]                s_axi_bresp,
   output logic                      s_axi_bvalid,
   input  logic                      s_axi_bready,
   // AXI4-Lite read address / data
   input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
   input  logic [2:0]                s_axi_arprot,
   input  logic                      s_axi_arvalid,
   output logic                      s_axi_arready,
   output logic [DATA_WIDTH-1:0]     s_axi_rdata,
   output logic [1:0]                s_axi_rresp,
   output logic                      s_axi_rvalid,
   input  logic                      s_axi_rready,
   // byte streams
   output logic [7:0]                tx_data_o,
   output logic                      tx_v_o,
   input  logic                      tx_ready_i,
   input  logic [7:0]                rx_data_i,
   input  logic                      rx_v_i,
   output logic                      rx_ready_o,
   output logic                      interrupt_o
);

   localparam int                c_IDX_W    = $clog2(FIFO_DEPTH);
   localparam logic [c_IDX_W:0]  c_FULL_CNT = (c_IDX_W+1)'(FIFO_DEPTH);
   localparam logic [c_IDX_W:0]  c_PTR_ONE  = (c_IDX_W+1)'(1);
   localparam logic [1:0]        c_SEL_RX   = 2'd0;
   localparam logic [1:0]        c_SEL_TX   = 2'd1;
   localparam logic [1:0]        c_SEL_STAT = 2'd2;
   localparam logic [1:0]        c_SEL_CTRL = 2'd3;

   logic                   r_awready;
   logic                   r_bvalid;
   logic                   r_arready;
   logic                   r_rvalid;
   logic [DATA_WIDTH-1:0]  r_rdata;
   logic                   r_rx_ready;
   logic                   r_overrun;
   logic                   r_intr_en;
   logic                   r_interrupt;

   logic [7:0]             r_tx_mem [FIFO_DEPTH];
   logic [7:0]             r_rx_mem [FIFO_DEPTH];
   logic [c_IDX_W:0]       r_tx_wptr, r_tx_rptr, r_rx_wptr, r_rx_rptr;

   logic [c_IDX_W:0]       w_tx_count, w_rx_count;
   logic                   w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
   logic                   w_wr_fire, w_wr_en, w_rd_fire;
   logic [1:0]             w_wr_sel, w_rd_sel;
   logic                   w_tx_push, w_tx_pop, w_tx_clr;
   logic                   w_rx_push_req, w_rx_push, w_rx_pop, w_rx_clr;
   logic                   w_ctrl_wr, w_rx_rise, w_tx_drain;
   logic [7:0]             w_stat;
   logic [DATA_WIDTH-1:0]  w_rd_data;
   logic                   w_unused_ok;

   assign w_tx_count = r_tx_wptr - r_tx_rptr;
   assign w_rx_count = r_rx_wptr - r_rx_rptr;
   assign w_tx_empty = (w_tx_count == '0);
   assign w_tx_full  = (w_tx_count == c_FULL_CNT);
   assign w_rx_empty = (w_rx_count == '0);
   assign w_rx_full  = (w_rx_count == c_FULL_CNT);

   assign w_wr_fire  = r_awready & s_axi_awvalid & s_axi_wvalid;
   assign w_wr_en    = w_wr_fire & s_axi_wstrb[0];
   assign w_wr_sel   = s_axi_awaddr[3:2];
   assign w_rd_fire  = r_arready & s_axi_arvalid;
   assign w_rd_sel   = s_axi_araddr[3:2];

   assign w_ctrl_wr  = w_wr_en & (w_wr_sel == c_SEL_CTRL);
   assign w_tx_clr   = w_ctrl_wr & s_axi_wdata[0];
   assign w_rx_clr   = w_ctrl_wr & s_axi_wdata[1];

   // Full/empty are pre-cycle: a same-cycle pop never makes room for a push.
   assign w_tx_push     = w_wr_en & (w_wr_sel == c_SEL_TX) & ~w_tx_full;
   assign w_tx_pop      = ~w_tx_empty & tx_ready_i;
   assign w_rx_push_req = rx_v_i & r_rx_ready;
   assign w_rx_push     = w_rx_push_req & ~w_rx_full;
   assign w_rx_pop      = w_rd_fire & (w_rd_sel == c_SEL_RX) & ~w_rx_empty;

   assign w_rx_rise  = w_rx_push & w_rx_empty & ~w_rx_clr;
   assign w_tx_drain = w_tx_pop & (w_tx_count == c_PTR_ONE) & ~w_tx_push & ~w_tx_clr;

   assign w_stat = {2'b00, r_overrun, r_intr_en, w_tx_full, w_tx_empty, w_rx_full, ~w_rx_empty};

   always_comb begin
      w_rd_data = '0;
      case (w_rd_sel)
         c_SEL_RX:   if (!w_rx_empty) w_rd_data[7:0] = r_rx_mem[r_rx_rptr[c_IDX_W-1:0]];
         c_SEL_STAT: w_rd_data[7:0] = w_stat;
         default:    w_rd_data = '0;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_awready   <= 1'b0;
         r_bvalid    <= 1'b0;
         r_arready   <= 1'b0;
         r_rvalid    <= 1'b0;
         r_rdata     <= '0;
         r_rx_ready  <= 1'b0;
         r_overrun   <= 1'b0;
         r_intr_en   <= 1'b0;
         r_interrupt <= 1'b0;
      end else begin
         r_rx_ready  <= 1'b1;
         // The !r_awready term keeps the accept strobe to a single cycle.
         r_awready   <= s_axi_awvalid & s_axi_wvalid & ~r_bvalid & ~r_awready;
         if (w_wr_fire)
            r_bvalid <= 1'b1;
         else if (s_axi_bready)
            r_bvalid <= 1'b0;

         r_arready   <= s_axi_arvalid & ~r_rvalid & ~r_arready;
         if (w_rd_fire) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
         end else if (s_axi_rready) begin
            r_rvalid <= 1'b0;
         end

         if (w_rx_push_req & w_rx_full)
            r_overrun <= 1'b1;
         else if (w_rd_fire & (w_rd_sel == c_SEL_STAT))
            r_overrun <= 1'b0;

         if (w_ctrl_wr)
            r_intr_en <= s_axi_wdata[4];
         r_interrupt <= r_intr_en & (w_rx_rise | w_tx_drain);
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_tx_wptr <= '0;
         r_tx_rptr <= '0;
         r_rx_wptr <= '0;
         r_rx_rptr <= '0;
      end else begin
         if (w_tx_clr) begin
            r_tx_wptr <= '0;
            r_tx_rptr <= '0;
         end else begin
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + c_PTR_ONE;
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + c_PTR_ONE;
         end
         if (w_rx_clr) begin
            r_rx_wptr <= '0;
            r_rx_rptr <= '0;
         end else begin
            if (w_rx_push) r_rx_wptr <= r_rx_wptr + c_PTR_ONE;
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + c_PTR_ONE;
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (w_tx_push) r_tx_mem[r_tx_wptr[c_IDX_W-1:0]] <= s_axi_wdata[7:0];
      if (w_rx_push) r_rx_mem[r_rx_wptr[c_IDX_W-1:0]] <= rx_data_i;
   end

   assign s_axi_awready = r_awready;
   assign s_axi_wready  = r_awready;
   assign s_axi_bresp   = 2'b00;
   assign s_axi_bvalid  = r_bvalid;
   assign s_axi_arready = r_arready;
   assign s_axi_rdata   = r_rdata;
   assign s_axi_rresp   = 2'b00;
   assign s_axi_rvalid  = r_rvalid;
   assign tx_data_o     = r_tx_mem[r_tx_rptr[c_IDX_W-1:0]];
   assign tx_v_o        = ~w_tx_empty;
   assign rx_ready_o    = r_rx_ready;
   assign interrupt_o   = r_interrupt;

   assign w_unused_ok = ^{s_axi_awprot, s_axi_arprot,
                          s_axi_awaddr[ADDR_WIDTH-1:4], s_axi_awaddr[1:0],
                          s_axi_araddr[ADDR_WIDTH-1:4], s_axi_araddr[1:0],
                          s_axi_wdata[DATA_WIDTH-1:8], s_axi_wstrb[DATA_WIDTH/8-1:1]};

endmodule

`default_nettype wire

// File: tb/tb_axil_uart_lite_responder.sv
// ============================================================================
//  Module   : tb_axil_uart_lite_responder
//  Purpose  : Directed scoreboard bench for axil_uart_lite_responder.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axil_uart_lite_responder;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [27:0] awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;
   logic [7:0]  tx_data, rx_data;
   logic        tx_v, tx_ready, rx_v, rx_ready, irq;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          n_irq   = 0;
   logic [7:0]  tx_q[$];
   logic [31:0] rd_q[$];

   always #5 aclk = ~aclk;

   axil_uart_lite_responder #(.ADDR_WIDTH(28), .DATA_WIDTH(32), .FIFO_DEPTH(16)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
      .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
      .tx_data_o(tx_data), .tx_v_o(tx_v), .tx_ready_i(tx_ready),
      .rx_data_i(rx_data), .rx_v_i(rx_v), .rx_ready_o(rx_ready), .interrupt_o(irq)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   // A handshake on the TX stream completes at the posedge following this negedge.
   always @(negedge aclk) begin
      if (aresetn === 1'b1 && tx_v === 1'b1 && tx_ready === 1'b1) begin
         if (tx_q.size() == 0) check("tx_unexpected_byte", {24'h0, tx_data}, 32'hFFFF_FFFF);
         else                  check("tx_byte", {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
      end
      if (irq === 1'b1) n_irq++;
   end

   task automatic wait_aw_accept();
      int k = 0;
      do begin tick(); k++; end while (awready !== 1'b1 && k < 40);
      check("awready", {31'h0, awready}, 32'h1);
      check("wready", {31'h0, wready}, 32'h1);
      tick();
      awvalid = 1'b0;
      wvalid  = 1'b0;
   endtask

   task automatic wait_b();
      int k = 0;
      while (bvalid !== 1'b1 && k < 40) begin tick(); k++; end
      check("bvalid", {31'h0, bvalid}, 32'h1);
      check("bresp", {30'h0, bresp}, 32'h0);
      tick();
      bready = 1'b0;
   endtask

   task automatic axi_write(input logic [27:0] a, input logic [31:0] d, input logic [3:0] s);
      awaddr = a; wdata = d; wstrb = s;
      awvalid = 1'b1; wvalid = 1'b1;
      wait_aw_accept();
      bready = 1'b1;
      wait_b();
   endtask

   task automatic axi_read(input string tag, input logic [27:0] a, input logic [31:0] exp);
      int k = 0;
      rd_q.push_back(exp);
      araddr = a; arvalid = 1'b1;
      do begin tick(); k++; end while (arready !== 1'b1 && k < 40);
      tick();
      arvalid = 1'b0;
      rready  = 1'b1;
      k = 0;
      while (rvalid !== 1'b1 && k < 40) begin tick(); k++; end
      if (rvalid !== 1'b1) check({tag, "_rvalid"}, {31'h0, rvalid}, 32'h1);
      check(tag, rdata, rd_q.pop_front());
      check({tag, "_rresp"}, {30'h0, rresp}, 32'h0);
      tick();
      rready = 1'b0;
   endtask

   task automatic rx_send(input logic [7:0] b);
      rx_data = b; rx_v = 1'b1;
      tick();
      rx_v = 1'b0;
   endtask

   initial begin
      int irq_base;
      int seen;
      aresetn = 1'b0; awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
      awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
      wdata = '0; wstrb = '0; tx_ready = 0; rx_data = '0; rx_v = 0;
      repeat (3) tick();
      check("rst_awready", {31'h0, awready}, 32'h0);
      check("rst_bvalid",  {31'h0, bvalid},  32'h0);
      check("rst_rvalid",  {31'h0, rvalid},  32'h0);
      check("rst_rdata",   rdata,            32'h0);
      check("rst_tx_v",    {31'h0, tx_v},    32'h0);
      check("rst_rx_ready",{31'h0, rx_ready},32'h0);
      check("rst_irq",     {31'h0, irq},     32'h0);
      aresetn = 1'b1;
      tick();
      check("rx_ready_after_rst", {31'h0, rx_ready}, 32'h1);
      axi_read("stat_idle", 28'h8, 32'h04);

      // TX stream in order
      tx_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tx_q.push_back(8'h41 + 8'(i));
         axi_write(28'h4, 32'h41 + i, 4'hF);
      end
      repeat (4) tick();
      check("tx_q_drained", tx_q.size(), 0);
      check("tx_v_final", {31'h0, tx_v}, 32'h0);

      // wstrb[0]=0 has no effect
      tx_ready = 1'b0;
      axi_write(28'h4, 32'h99, 4'hE);
      tick();
      check("wstrb0_ignored", {31'h0, tx_v}, 32'h0);

      // TX overflow: 17th byte dropped
      for (int i = 0; i < 17; i++) begin
         if (i < 16) tx_q.push_back(8'(i));
         axi_write(28'h4, 32'(i), 4'h1);
      end
      axi_read("stat_tx_full", 28'h8, 32'h08);
      tx_ready = 1'b1;
      repeat (24) tick();
      check("tx_overflow_q", tx_q.size(), 0);
      check("tx_overflow_v", {31'h0, tx_v}, 32'h0);

      // RX readback
      rx_send(8'h55);
      rx_send(8'hAA);
      tick();
      axi_read("stat_rx_valid", 28'h8, 32'h05);
      axi_read("rx_first",  28'h0, 32'h55);
      axi_read("rx_second", 28'h0, 32'hAA);
      axi_read("rx_empty",  28'h0, 32'h00);
      axi_read("stat_rx_gone", 28'h8, 32'h04);

      // RX overflow: overrun set, 17th byte lost, overrun clears on STAT read
      for (int i = 0; i < 17; i++) rx_send(8'h10 + 8'(i));
      tick();
      axi_read("stat_overrun", 28'h8, 32'h27);
      axi_read("stat_overrun_clr", 28'h8, 32'h07);
      for (int i = 0; i < 16; i++) axi_read("rx_overflow_data", 28'h0, 32'h10 + i);
      axi_read("rx_17th_absent", 28'h0, 32'h00);

      // Interrupts
      axi_write(28'hC, 32'h10, 4'h1);
      irq_base = n_irq;
      rx_send(8'h5A);
      repeat (4) tick();
      check("irq_rx", n_irq - irq_base, 1);
      tx_ready = 1'b1;
      tx_q.push_back(8'h33);
      axi_write(28'h4, 32'h33, 4'h1);
      repeat (4) tick();
      check("irq_tx_drain", n_irq - irq_base, 2);
      tx_ready = 1'b0;
      axi_write(28'h4, 32'h44, 4'h1);
      axi_read("stat_both_busy", 28'h8, 32'h11);
      axi_write(28'hC, 32'h13, 4'h1);
      repeat (3) tick();
      axi_read("stat_after_ctrl", 28'h8, 32'h14);
      check("ctrl_tx_v", {31'h0, tx_v}, 32'h0);
      check("irq_no_ctrl_reset", n_irq - irq_base, 2);
      axi_read("rx_after_ctrl", 28'h0, 32'h00);

      // B back-pressure blocks a second write
      tx_ready = 1'b1;
      tx_q.push_back(8'h66);
      awaddr = 28'h4; wdata = 32'h66; wstrb = 4'h1; awvalid = 1; wvalid = 1; bready = 0;
      wait_aw_accept();
      check("b_pending", {31'h0, bvalid}, 32'h1);
      tx_q.push_back(8'h77);
      awaddr = 28'h4; wdata = 32'h77; awvalid = 1; wvalid = 1;
      seen = 0;
      repeat (5) begin
         tick();
         if (awready === 1'b1) seen = 1;
      end
      check("aw_blocked", seen, 0);
      check("b_held", {31'h0, bvalid}, 32'h1);
      bready = 1'b1;
      tick();
      bready = 1'b0;
      wait_aw_accept();
      bready = 1'b1;
      wait_b();
      repeat (4) tick();
      check("tx_q_backpressure", tx_q.size(), 0);

      // Reset during an outstanding read
      araddr = 28'h8; arvalid = 1; rready = 0;
      seen = 0;
      do begin tick(); seen++; end while (arready !== 1'b1 && seen < 40);
      tick();
      arvalid = 1'b0;
      check("r_pending", {31'h0, rvalid}, 32'h1);
      aresetn = 1'b0;
      tick();
      check("rst_mid_rvalid", {31'h0, rvalid}, 32'h0);
      check("rst_mid_rx_ready", {31'h0, rx_ready}, 32'h0);
      aresetn = 1'b1;
      tick();
      axi_read("stat_after_rst", 28'h8, 32'h04);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1);
   end

endmodule

`default_nettype wire
